// File: rtl/horizontal_tf_reader_if.sv
// Bus bundle between the horizontal twiddle reader, its eight ROM banks and
// the radix-16 butterfly twiddle consumer.
interface horizontal_tf_reader_if #(
  parameter int P_WIDTH  = 64,
  parameter int SD_WIDTH = 128,
  parameter int A_WIDTH  = 4
);
  // ROM side (shared enable/address, per-bank read data)
  logic                rom_CEN;
  logic [A_WIDTH-1:0]  rom_addr;
  logic [P_WIDTH-1:0]  ROM0_in;
  logic [SD_WIDTH-1:0] ROM1_in;
  logic [SD_WIDTH-1:0] ROM2_in;
  logic [SD_WIDTH-1:0] ROM3_in;
  logic [SD_WIDTH-1:0] ROM4_in;
  logic [SD_WIDTH-1:0] ROM5_in;
  logic [SD_WIDTH-1:0] ROM6_in;
  logic [SD_WIDTH-1:0] ROM7_in;

  // Twiddle stream side
  logic [P_WIDTH-1:0]  tf_out;
  logic                tf_valid;
  logic                tf_ready;
  logic [3:0]          tf_idx;
  logic [A_WIDTH-1:0]  grp_idx;

  modport master (
    output rom_CEN, rom_addr, tf_out, tf_valid, tf_idx, grp_idx,
    input  ROM0_in, ROM1_in, ROM2_in, ROM3_in, ROM4_in, ROM5_in, ROM6_in,
           ROM7_in, tf_ready
  );

  modport slave (
    input  rom_CEN, rom_addr, tf_out, tf_valid, tf_idx, grp_idx,
    output ROM0_in, ROM1_in, ROM2_in, ROM3_in, ROM4_in, ROM5_in, ROM6_in,
           ROM7_in, tf_ready
  );
endinterface

// File: rtl/horizontal_tf_reader.sv
// Horizontal twiddle reader: sweeps the ROM bank addresses, captures one
// entry from all eight banks per address and streams the 15 unpacked
// twiddles (tf1..tf15) over a valid/ready handshake.
module horizontal_tf_reader #(
  parameter int P_WIDTH  = 64,
  parameter int SD_WIDTH = 128,
  parameter int A_WIDTH  = 4,
  parameter int NUM_ADDR = 16,
  parameter int ROM_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,   // active-high asynchronous reset
  input  logic                   start,
  horizontal_tf_reader_if.master bus,
  output logic                   busy,
  output logic                   done
);

  localparam int BUF_W = P_WIDTH + 7 * SD_WIDTH;
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(NUM_ADDR - 1);
  localparam logic [CNT_W-1:0]   LAST_WAIT = CNT_W'(ROM_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, SEND = 2'd3} state_t;

  state_t             state_r,    state_s;
  logic               start_r,    start_s;    // run request seen in IDLE
  logic [A_WIDTH-1:0] addr_r,     addr_s;
  logic [CNT_W-1:0]   wait_r,     wait_s;
  logic [BUF_W-1:0]   buf_r,      buf_s;
  logic               cen_r,      cen_s;
  logic [P_WIDTH-1:0] tf_out_r,   tf_out_s;
  logic               tf_valid_r, tf_valid_s;
  logic [3:0]         tf_idx_r,   tf_idx_s;
  logic [A_WIDTH-1:0] grp_r,      grp_s;
  logic               busy_r,     busy_s;
  logic               done_r,     done_s;

  logic [P_WIDTH-1:0] beat_s [16];
  logic [3:0]         idx_inc_s;

  // Slice the captured entry into beats; beat i sits at word i-1 of the buffer.
  always_comb begin
    beat_s[0] = '0;
    for (int i = 1; i < 16; i++) begin
      beat_s[i] = buf_r[(i-1)*P_WIDTH +: P_WIDTH];
    end
  end

  // Next-state and next-output logic for the sweep/capture/serialise FSM.
  always_comb begin
    state_s    = state_r;
    start_s    = start_r;
    addr_s     = addr_r;
    wait_s     = wait_r;
    buf_s      = buf_r;
    cen_s      = cen_r;
    tf_out_s   = tf_out_r;
    tf_valid_s = tf_valid_r;
    tf_idx_s   = tf_idx_r;
    grp_s      = grp_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    idx_inc_s  = tf_idx_r + 4'd1;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start_r) begin
          state_s = REQ;
          start_s = 1'b0;
          addr_s  = '0;
          cen_s   = 1'b0;
          busy_s  = 1'b1;
        end else if (start) begin
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      REQ: begin
        cen_s   = 1'b1;
        wait_s  = '0;
        state_s = WAIT;
      end
      WAIT: begin
        if (wait_r == LAST_WAIT) begin
          buf_s      = {bus.ROM7_in, bus.ROM6_in, bus.ROM5_in, bus.ROM4_in,
                        bus.ROM3_in, bus.ROM2_in, bus.ROM1_in, bus.ROM0_in};
          tf_out_s   = bus.ROM0_in;
          tf_idx_s   = 4'd1;
          tf_valid_s = 1'b1;
          grp_s      = addr_r;
          state_s    = SEND;
        end else begin
          wait_s = wait_r + CNT_W'(1);
        end
      end
      SEND: begin
        if (tf_valid_r && bus.tf_ready) begin
          if (tf_idx_r == 4'd15) begin
            tf_valid_s = 1'b0;
            // Stop at the final address rather than letting addr wrap.
            if (addr_r != LAST_ADDR) begin
              addr_s  = addr_r + A_WIDTH'(1);
              cen_s   = 1'b0;
              state_s = REQ;
            end else begin
              done_s  = 1'b1;
              state_s = IDLE;
            end
          end else begin
            tf_idx_s = idx_inc_s;
            tf_out_s = beat_s[idx_inc_s];
          end
        end else begin
          tf_idx_s = tf_idx_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset asynchronously forces the idle values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r    <= IDLE;
      start_r    <= 1'b0;
      addr_r     <= '0;
      wait_r     <= '0;
      buf_r      <= '0;
      cen_r      <= 1'b1;
      tf_out_r   <= '0;
      tf_valid_r <= 1'b0;
      tf_idx_r   <= 4'd0;
      grp_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      start_r    <= start_s;
      addr_r     <= addr_s;
      wait_r     <= wait_s;
      buf_r      <= buf_s;
      cen_r      <= cen_s;
      tf_out_r   <= tf_out_s;
      tf_valid_r <= tf_valid_s;
      tf_idx_r   <= tf_idx_s;
      grp_r      <= grp_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.rom_CEN  = cen_r;
  assign bus.rom_addr = addr_r;
  assign bus.tf_out   = tf_out_r;
  assign bus.tf_valid = tf_valid_r;
  assign bus.tf_idx   = tf_idx_r;
  assign bus.grp_idx  = grp_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_horizontal_tf_reader.sv
// Directed bench for horizontal_tf_reader: a short 2-address sweep with
// 1-cycle ROMs (plain run, backpressure, stray start, mid-run reset) and a
// full 16-address sweep with 3-cycle ROMs.
module tb_horizontal_tf_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic ready_a = 1'b1, ready_b = 1'b1;
  logic busy_a, done_a, busy_b, done_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  horizontal_tf_reader_if #(.P_WIDTH(64), .SD_WIDTH(128), .A_WIDTH(4)) if_a ();
  horizontal_tf_reader_if #(.P_WIDTH(64), .SD_WIDTH(128), .A_WIDTH(4)) if_b ();

  horizontal_tf_reader #(.P_WIDTH(64), .SD_WIDTH(128), .A_WIDTH(4),
                         .NUM_ADDR(2), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst), .start(start_a), .bus(if_a.master),
    .busy(busy_a), .done(done_a));

  horizontal_tf_reader #(.P_WIDTH(64), .SD_WIDTH(128), .A_WIDTH(4),
                         .NUM_ADDR(16), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst), .start(start_b), .bus(if_b.master),
    .busy(busy_b), .done(done_b));

  // Twiddle idx of address a is {a, idx}; junk when the ROM has no fresh data.
  function automatic logic [63:0] word(input logic ok, input logic [3:0] a, input int idx);
    return ok ? ((64'(a) << 32) | 64'(idx)) : 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  function automatic logic [127:0] bank(input logic ok, input logic [3:0] a, input int k);
    return {word(ok, a, 2*k+1), word(ok, a, 2*k)};
  endfunction

  // ROM models: capture address on a CEN-low edge, data shows ROM_LAT-1 edges later.
  logic       va;
  logic [3:0] aa;
  logic       vb [3];
  logic [3:0] ab [3];
  always @(posedge clk) begin
    va    <= (if_a.rom_CEN === 1'b0);
    aa    <= if_a.rom_addr;
    vb[0] <= (if_b.rom_CEN === 1'b0);
    ab[0] <= if_b.rom_addr;
    vb[1] <= vb[0];  ab[1] <= ab[0];
    vb[2] <= vb[1];  ab[2] <= ab[1];
  end

  assign if_a.ROM0_in = word(va === 1'b1, aa, 1);
  assign if_a.ROM1_in = bank(va === 1'b1, aa, 1);
  assign if_a.ROM2_in = bank(va === 1'b1, aa, 2);
  assign if_a.ROM3_in = bank(va === 1'b1, aa, 3);
  assign if_a.ROM4_in = bank(va === 1'b1, aa, 4);
  assign if_a.ROM5_in = bank(va === 1'b1, aa, 5);
  assign if_a.ROM6_in = bank(va === 1'b1, aa, 6);
  assign if_a.ROM7_in = bank(va === 1'b1, aa, 7);
  assign if_a.tf_ready = ready_a;

  assign if_b.ROM0_in = word(vb[2] === 1'b1, ab[2], 1);
  assign if_b.ROM1_in = bank(vb[2] === 1'b1, ab[2], 1);
  assign if_b.ROM2_in = bank(vb[2] === 1'b1, ab[2], 2);
  assign if_b.ROM3_in = bank(vb[2] === 1'b1, ab[2], 3);
  assign if_b.ROM4_in = bank(vb[2] === 1'b1, ab[2], 4);
  assign if_b.ROM5_in = bank(vb[2] === 1'b1, ab[2], 5);
  assign if_b.ROM6_in = bank(vb[2] === 1'b1, ab[2], 6);
  assign if_b.ROM7_in = bank(vb[2] === 1'b1, ab[2], 7);
  assign if_b.tf_ready = ready_b;

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_cen"},   0, 64'(if_a.rom_CEN),  64'd1);
    chk({tag, "_addr"},  0, 64'(if_a.rom_addr), 64'd0);
    chk({tag, "_out"},   0, if_a.tf_out,        64'd0);
    chk({tag, "_valid"}, 0, 64'(if_a.tf_valid), 64'd0);
    chk({tag, "_idx"},   0, 64'(if_a.tf_idx),   64'd0);
    chk({tag, "_grp"},   0, 64'(if_a.grp_idx),  64'd0);
    chk({tag, "_busy"},  0, 64'(busy_a),        64'd0);
    chk({tag, "_done"},  0, 64'(done_a),        64'd0);
  endtask

  // Two-group run on dut_a; s>0 stalls tf_ready for s cycles while idx7 is shown,
  // inj pulses start in the middle of group 0.
  task automatic run_a(input int s, input bit inj);
    logic       ev, g;
    int         idx;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 40 + s; c++) begin
      step();
      ready_a = !(s > 0 && c >= 9 && c < 9 + s);
      start_a = inj && (c == 10);
      ev = (c >= 3 && c <= 17 + s) || (c >= 20 + s && c <= 34 + s);
      chk("a_valid", c, 64'(if_a.tf_valid), 64'(ev));
      chk("a_cen",   c, 64'(if_a.rom_CEN),  64'(!(c == 1 || c == 18 + s)));
      chk("a_addr",  c, 64'(if_a.rom_addr), (c < 18 + s) ? 64'd0 : 64'd1);
      chk("a_busy",  c, 64'(busy_a),        64'(c <= 35 + s));
      chk("a_done",  c, 64'(done_a),        64'(c == 35 + s));
      if (ev) begin
        g   = (c >= 20 + s);
        idx = g ? c - 19 - s : (c < 9 ? c - 2 : (c < 9 + s ? 7 : c - 2 - s));
        chk("a_idx", c, 64'(if_a.tf_idx),  64'(idx));
        chk("a_grp", c, 64'(if_a.grp_idx), 64'(g));
        chk("a_out", c, if_a.tf_out,       (64'(g) << 32) | 64'(idx));
      end
    end
    start_a = 1'b0;
    ready_a = 1'b1;
  endtask

  initial begin
    logic ev;
    int   g, ph;

    // Reset state
    repeat (3) step();
    chk_reset_a("rst");
    chk("rst_b_cen",  0, 64'(if_b.rom_CEN), 64'd1);
    chk("rst_b_busy", 0, 64'(busy_b),       64'd0);
    rst = 1'b0;
    repeat (2) step();

    // Plain run with a stray start during SEND, then a backpressured run
    run_a(0, 1'b1);
    repeat (3) step();
    run_a(5, 1'b0);
    repeat (3) step();

    // Reset in the middle of SEND: outputs clear at once, no done
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (6) step();
    chk("mid_valid_before", 6, 64'(if_a.tf_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk_reset_a("midrst");
    repeat (2) step();
    chk("midrst_done", 0, 64'(done_a), 64'd0);
    chk("midrst_busy", 0, 64'(busy_a), 64'd0);
    rst = 1'b0;
    repeat (2) step();
    run_a(0, 1'b0);

    // Full 16-address sweep with 3-cycle ROM latency
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 310; c++) begin
      step();
      g  = (c - 1) / 19;
      ph = (c - 1) % 19;
      if (c <= 304) begin
        ev = (ph >= 4);
        chk("b_valid", c, 64'(if_b.tf_valid), 64'(ev));
        chk("b_cen",   c, 64'(if_b.rom_CEN),  64'(ph != 0));
        chk("b_addr",  c, 64'(if_b.rom_addr), 64'(g));
        if (ev) begin
          chk("b_idx", c, 64'(if_b.tf_idx),  64'(ph - 3));
          chk("b_grp", c, 64'(if_b.grp_idx), 64'(g));
          chk("b_out", c, if_b.tf_out,       (64'(g) << 32) | 64'(ph - 3));
        end
      end else begin
        chk("b_valid_end", c, 64'(if_b.tf_valid), 64'd0);
        chk("b_cen_end",   c, 64'(if_b.rom_CEN),  64'd1);
        chk("b_addr_end",  c, 64'(if_b.rom_addr), 64'd15);
      end
      chk("b_busy", c, 64'(busy_b), 64'(c <= 305));
      chk("b_done", c, 64'(done_b), 64'(c == 305));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/horizontal_tf_reader.md
Name: horizontal_tf_reader

Overview:
- Read side of the horizontal twiddle ROM banks (ROM0..ROM7) that the horizontal twiddle generator fills.
- Sweeps the bank address range, fetches one entry per address from all eight banks, and unpacks it into 15 ordered 64-bit twiddles (tf1..tf15).
- Streams those twiddles to the radix-16 butterfly datapath over a valid/ready handshake.
- Sits between the ROM banks and the butterfly twiddle multipliers.

Parameters:
- P_WIDTH, 64, twiddle word width; ROM0 data width.
- SD_WIDTH, 128, ROM1..ROM7 data width (two packed twiddles).
- A_WIDTH, 4, ROM address width.
- NUM_ADDR, 16, addresses swept per run (1..2^A_WIDTH).
- ROM_LAT, 1, ROM read latency in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-high reset (rst_n=1 resets).
- start  in  1  one-cycle run request, sampled in IDLE only.
- rom_CEN  out  1  ROM chip enable, active-low, shared by all banks.
- rom_addr  out  A_WIDTH  ROM read address, shared by all banks.
- ROM0_in  in  P_WIDTH  ROM0 read data.
- ROM1_in..ROM7_in  in  SD_WIDTH each  ROM1..ROM7 read data.
- tf_out  out  P_WIDTH  twiddle word.
- tf_valid  out  1  tf_out valid.
- tf_ready  in  1  consumer accepts tf_out.
- tf_idx  out  4  twiddle index 1..15 of tf_out.
- grp_idx  out  A_WIDTH  address that tf_out came from.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: rom_CEN=1, rom_addr=0, tf_out=0, tf_valid=0, tf_idx=0, grp_idx=0, busy=0, done=0, state=IDLE, internal buffer=0.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, SEND.
  - IDLE: on start=1 -> REQ with addr=0. start in any other state is ignored.
  - REQ: exactly 1 cycle. rom_CEN=0, rom_addr=current addr. -> WAIT.
  - WAIT: exactly ROM_LAT cycles, rom_CEN=1. On the final WAIT edge, latch all 8 bank words into a 960-bit buffer. -> SEND with tf_idx=1.
  - SEND: serialise 15 beats.
- Beat unpack order:
  - idx1 = ROM0_in.
  - idx2k = ROMk_in[63:0] and idx2k+1 = ROMk_in[127:64], for k=1..7.
  - This gives idx2..idx15.
- Handshake:
  - A beat transfers on tf_valid & tf_ready.
  - While tf_ready=0: tf_out, tf_idx, grp_idx are held and tf_valid stays 1; valid never drops mid-group.
- After the idx15 transfer:
  - if addr < NUM_ADDR-1: addr++, -> REQ, tf_valid=0;
  - else: done=1 for one cycle, -> IDLE.
- Timing:
  - first tf_valid rises ROM_LAT+2 cycles after the edge that samples start;
  - group gap is ROM_LAT+1 cycles with tf_valid low;
  - best-case run length = NUM_ADDR*(15+ROM_LAT+1)+1 cycles.
- Address wrap: when NUM_ADDR=2^A_WIDTH, addr never wraps internally; the run terminates at the final address.
- busy=1 from the REQ entry through the done cycle inclusive; busy=0 in the cycle after done.
- Reset mid-operation: immediate return to IDLE with reset values. No done pulse. rom_CEN returns to 1 asynchronously.
- tf_ready asserted while tf_valid=0 has no effect.

Test Plan:
- Reset with rst_n=1 mid-SEND -> all outputs return to reset values within the same cycle; no done; new start after release runs from addr 0.
- Single run, NUM_ADDR=2, ROM_LAT=1, tf_ready=1, ROM0=64'h1, ROMk={64'h(2k+1),64'h(2k)} -> tf_out sequence 1..15 for grp 0, then 1..15 for grp 1; tf_valid first high 3 cycles after start; done pulse exactly at cycle 35.
- Backpressure: tf_ready=0 for 5 cycles at idx7 -> tf_out/tf_idx held at 7, tf_valid stays 1; stream resumes with idx8, no beat lost or duplicated.
- start pulsed during SEND -> ignored; exactly NUM_ADDR groups output; one done.
- ROM_LAT=3 -> rom_CEN low exactly 1 cycle per group; capture on the 3rd WAIT edge; group gap of 4 cycles.
- NUM_ADDR=16, A_WIDTH=4 -> rom_addr runs 0..15 once; done after the idx15 beat of grp 15; rom_addr does not wrap to 0 before done.
